// File: rtl/mac_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mac_sequencer: packs byte-serial operands, launches the 4-lane dot-product |
// | datapath, saturating-accumulates results, returns sum as two 10-bit beats. |
// | Revision: 1.0                                                              |
// +--------------------------------------------------------------------------+
module mac_sequencer #(
  parameter int LAT   = 1,
  parameter int ACC_W = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic [31:0] mac_data,
  output logic [31:0] mac_weights,
  output logic        mac_start,
  input  logic [17:0] mac_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [9:0]  out_data,
  output logic        out_hi,
  output logic        sat,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_LOAD_D = 3'd0,
    S_LOAD_W = 3'd1,
    S_WAIT   = 3'd2,
    S_ACC    = 3'd3,
    S_OUT_LO = 3'd4,
    S_OUT_HI = 3'd5
  } state_t;

  localparam logic [1:0] WAIT_END = 2'(LAT - 1);

  state_t           state_q, state_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [1:0]       wait_q, wait_d;
  logic [31:0]      data_q, data_d;
  logic [31:0]      weights_q, weights_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             sat_q, sat_d;
  logic             last_q, last_d;
  logic             clr_sat_q, clr_sat_d;
  logic             accept;
  logic [ACC_W:0]   sum;

  // One extra bit above the accumulator exposes overflow of the add.
  assign sum = {1'b0, acc_q} + {{(ACC_W + 1 - 18){1'b0}}, mac_result};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wait_d    = wait_q;
    data_d    = data_q;
    weights_d = weights_q;
    acc_d     = acc_q;
    sat_d     = sat_q;
    last_d    = last_q;
    clr_sat_d = clr_sat_q;
    in_ready  = 1'b0;
    mac_start = 1'b0;
    out_valid = 1'b0;
    out_data  = 10'd0;
    out_hi    = 1'b0;
    accept    = 1'b0;

    case (state_q)
      S_LOAD_D: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (accept) begin
          data_d[{cnt_q, 3'b000} +: 8] = in_data;
          cnt_d = cnt_q + 2'd1;
          // The previous job's sat stays visible until the new job starts.
          if (clr_sat_q) begin
            sat_d     = 1'b0;
            clr_sat_d = 1'b0;
          end
          if (cnt_q == 2'd3) state_d = S_LOAD_W;
        end
      end
      S_LOAD_W: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (accept) begin
          weights_d[{cnt_q, 3'b000} +: 8] = in_data;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            last_d  = in_last;
            wait_d  = 2'd0;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        mac_start = (wait_q == 2'd0);
        if (wait_q == WAIT_END) state_d = S_ACC;
        else wait_d = wait_q + 2'd1;
      end
      S_ACC: begin
        if (sum[ACC_W]) begin
          acc_d = '1;
          sat_d = 1'b1;
        end else begin
          acc_d = sum[ACC_W-1:0];
        end
        state_d = last_q ? S_OUT_LO : S_LOAD_D;
      end
      S_OUT_LO: begin
        out_valid = 1'b1;
        out_data  = acc_q[9:0];
        if (out_ready) state_d = S_OUT_HI;
      end
      S_OUT_HI: begin
        out_valid = 1'b1;
        out_data  = acc_q[19:10];
        out_hi    = 1'b1;
        if (out_ready) begin
          acc_d     = '0;
          last_d    = 1'b0;
          clr_sat_d = 1'b1;
          state_d   = S_LOAD_D;
        end
      end
      default: state_d = S_LOAD_D;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_LOAD_D;
      cnt_q     <= 2'd0;
      wait_q    <= 2'd0;
      data_q    <= 32'd0;
      weights_q <= 32'd0;
      acc_q     <= '0;
      sat_q     <= 1'b0;
      last_q    <= 1'b0;
      clr_sat_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wait_q    <= wait_d;
      data_q    <= data_d;
      weights_q <= weights_d;
      acc_q     <= acc_d;
      sat_q     <= sat_d;
      last_q    <= last_d;
      clr_sat_q <= clr_sat_d;
    end
  end

  assign mac_data    = data_q;
  assign mac_weights = weights_q;
  assign sat         = sat_q;
  assign busy        = (state_q != S_LOAD_D) || (cnt_q != 2'd0);

endmodule
`default_nettype wire
